// File: rtl/reg_access_arbiter.sv
// rtl/reg_access_arbiter.sv - shares one register-bank port between NUM_REQ requesters, round-robin
// Define ARB_FIXED_PRIORITY_EN for fixed lowest-index-wins arbitration.
module reg_access_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int WORD_WIDTH  = 8,
  parameter int VALUE_WORDS = 4,
  parameter int RD_LATENCY  = 1,
  localparam int DW         = VALUE_WORDS * WORD_WIDTH
) (
  input  logic                           clk,
  input  logic                           i_reset,
  input  logic [NUM_REQ-1:0]             i_w_en,
  input  logic [NUM_REQ*WORD_WIDTH-1:0]  i_w_addr,
  input  logic [NUM_REQ*DW-1:0]          i_w_data,
  input  logic [NUM_REQ-1:0]             i_r_en,
  input  logic [NUM_REQ*WORD_WIDTH-1:0]  i_r_addr,
  output logic                           o_reg_w_en,
  output logic                           o_reg_r_en,
  output logic [WORD_WIDTH-1:0]          o_reg_addr,
  output logic [DW-1:0]                  o_reg_w_data,
  input  logic [DW-1:0]                  i_reg_r_data,
  output logic [DW-1:0]                  o_r_data,
  output logic [NUM_REQ-1:0]             o_r_valid,
  output logic [NUM_REQ-1:0]             o_pending,
  output logic [NUM_REQ-1:0]             o_drop
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(RD_LATENCY + 1) + 1;

  typedef enum logic [2:0] {IDLE, WRITE, READ, READ_WAIT, RETURN} state_t;

  state_t                 state, state_nx;
  logic [NUM_REQ-1:0]     slot_valid;
  logic [NUM_REQ-1:0]     slot_write;
  logic [WORD_WIDTH-1:0]  slot_addr [NUM_REQ];
  logic [DW-1:0]          slot_data [NUM_REQ];
  logic [NUM_REQ-1:0]     slot_retire;
  logic [IW-1:0]          winner;
  logic [IW-1:0]          pick;
  logic                   any_pending;
  logic [CW-1:0]          lat_cnt, lat_cnt_nx;
  logic                   retire;
  logic                   load_bank;
  logic                   capture_r;
  logic                   reg_w_en_nx;
  logic                   reg_r_en_nx;
  logic                   r_valid_nx;

`ifdef ARB_FIXED_PRIORITY_EN
  always_comb begin
    pick        = '0;
    any_pending = |slot_valid;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (slot_valid[k]) pick = IW'(k);
    end
  end
`else
  logic [IW-1:0] last_grant;
  logic [IW-1:0] cand;

  // Scan from farthest to nearest after last_grant so the nearest pending slot wins.
  always_comb begin
    pick        = '0;
    cand        = '0;
    any_pending = |slot_valid;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(last_grant) + k) % NUM_REQ);
      if (slot_valid[cand]) pick = cand;
    end
  end
`endif

  always_comb begin
    state_nx    = state;
    lat_cnt_nx  = lat_cnt;
    reg_w_en_nx = 1'b0;
    reg_r_en_nx = 1'b0;
    r_valid_nx  = 1'b0;
    load_bank   = 1'b0;
    capture_r   = 1'b0;
    retire      = 1'b0;
    case (state)
      IDLE: begin
        if (any_pending) begin
          load_bank = 1'b1;
          if (slot_write[pick]) begin
            state_nx    = WRITE;
            reg_w_en_nx = 1'b1;
          end else begin
            state_nx    = READ;
            reg_r_en_nx = 1'b1;
          end
        end
      end
      WRITE: begin
        retire   = 1'b1;
        state_nx = IDLE;
      end
      READ: begin
        lat_cnt_nx = CW'(RD_LATENCY);
        state_nx   = READ_WAIT;
      end
      READ_WAIT: begin
        lat_cnt_nx = lat_cnt - 1'b1;
        if (lat_cnt == CW'(1)) begin
          capture_r  = 1'b1;
          r_valid_nx = 1'b1;
          state_nx   = RETURN;
        end
      end
      RETURN: begin
        retire   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    slot_retire = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      slot_retire[i] = retire && (winner == IW'(i));
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      lat_cnt      <= '0;
      winner       <= '0;
      o_reg_w_en   <= 1'b0;
      o_reg_r_en   <= 1'b0;
      o_reg_addr   <= '0;
      o_reg_w_data <= '0;
      o_r_data     <= '0;
      o_r_valid    <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
      last_grant   <= IW'(NUM_REQ - 1);
`endif
    end else begin
      state      <= state_nx;
      lat_cnt    <= lat_cnt_nx;
      o_reg_w_en <= reg_w_en_nx;
      o_reg_r_en <= reg_r_en_nx;
      o_r_valid  <= r_valid_nx ? (NUM_REQ'(1) << winner) : '0;
      if (load_bank) begin
        winner       <= pick;
        o_reg_addr   <= slot_addr[pick];
        o_reg_w_data <= slot_data[pick];
      end
      if (capture_r) o_r_data <= i_reg_r_data;
`ifndef ARB_FIXED_PRIORITY_EN
      if (retire) last_grant <= winner;
`endif
    end
  end

  // A slot retiring on this edge may accept a new strobe on the same edge.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      slot_valid <= '0;
      slot_write <= '0;
      o_drop     <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_addr[i] <= '0;
        slot_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i_w_en[i] || i_r_en[i]) begin
          if (!slot_valid[i] || slot_retire[i]) begin
            slot_valid[i] <= 1'b1;
            slot_write[i] <= i_w_en[i];
            slot_addr[i]  <= i_w_en[i] ? i_w_addr[i*WORD_WIDTH +: WORD_WIDTH]
                                       : i_r_addr[i*WORD_WIDTH +: WORD_WIDTH];
            slot_data[i]  <= i_w_en[i] ? i_w_data[i*DW +: DW] : '0;
          end else begin
            o_drop[i] <= 1'b1;
          end
          if (i_w_en[i] && i_r_en[i]) o_drop[i] <= 1'b1;
        end else if (slot_retire[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign o_pending = slot_valid;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// tb/tb_reg_access_arbiter.sv - directed-vector bench for reg_access_arbiter
// Honours ARB_FIXED_PRIORITY_EN when the design is built with it.
module tb_reg_access_arbiter;

  localparam int RDL = 2;

`ifdef ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [1:0]  w_en;
  logic [15:0] w_addr;
  logic [63:0] w_data;
  logic [1:0]  r_en;
  logic [15:0] r_addr;
  logic        reg_w_en;
  logic        reg_r_en;
  logic [7:0]  reg_addr;
  logic [31:0] reg_w_data;
  logic [31:0] reg_r_data;
  logic [31:0] r_data;
  logic [1:0]  r_valid;
  logic [1:0]  pending;
  logic [1:0]  drop;

  int vectors;
  int miscompares;
  int wr_count;
  int rd_count;
  int rv_count;
  logic [3:0]  rd_pipe;
  logic [31:0] bank_val;

  reg_access_arbiter #(
    .NUM_REQ(2), .WORD_WIDTH(8), .VALUE_WORDS(4), .RD_LATENCY(RDL)
  ) dut (
    .clk(clk), .i_reset(rst),
    .i_w_en(w_en), .i_w_addr(w_addr), .i_w_data(w_data),
    .i_r_en(r_en), .i_r_addr(r_addr),
    .o_reg_w_en(reg_w_en), .o_reg_r_en(reg_r_en), .o_reg_addr(reg_addr),
    .o_reg_w_data(reg_w_data), .i_reg_r_data(reg_r_data),
    .o_r_data(r_data), .o_r_valid(r_valid), .o_pending(pending), .o_drop(drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: data is valid only RDL cycles after the read strobe.
  always @(posedge clk) rd_pipe <= {rd_pipe[2:0], reg_r_en};
  assign reg_r_data = rd_pipe[RDL-1] ? bank_val : 32'h0BAD_0BAD;

  always @(posedge clk) begin
    if (reg_w_en) wr_count <= wr_count + 1;
    if (reg_r_en) rd_count <= rd_count + 1;
    if (r_valid != 2'b00) rv_count <= rv_count + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    vectors++;
    if ({reg_w_en, reg_r_en, reg_addr, reg_w_data, r_data, r_valid, pending, drop} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got w%0b r%0b a%h d%h rd%h v%b p%b x%b want all 0",
               reg_w_en, reg_r_en, reg_addr, reg_w_data, r_data, r_valid, pending, drop);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    w_en = 2'b01; w_addr[7:0] = 8'h12; w_data[31:0] = 32'hDEAD_BEEF;
    tick();
    w_en = 2'b00;
    vectors++;
    if (pending !== 2'b01 || reg_w_en !== 1'b0) begin
      miscompares++;
      $display("FAIL write_n1: got pending=%b w_en=%b want 01/0", pending, reg_w_en);
    end
    tick();
    vectors++;
    if (reg_w_en !== 1'b1 || reg_r_en !== 1'b0 || reg_addr !== 8'h12 || reg_w_data !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL write_n2: got w%b r%b a%h d%h want 1 0 12 deadbeef", reg_w_en, reg_r_en, reg_addr, reg_w_data);
    end
    tick();
    vectors++;
    if (reg_w_en !== 1'b0 || pending !== 2'b00) begin
      miscompares++;
      $display("FAIL write_n3: got w_en=%b pending=%b want 0/00", reg_w_en, pending);
    end
  endtask

  task automatic test_read();
    r_en = 2'b10; r_addr[15:8] = 8'h05; bank_val = 32'hCAFE_F00D;
    tick();
    r_en = 2'b00;
    tick();
    vectors++;
    if (reg_r_en !== 1'b1 || reg_w_en !== 1'b0 || reg_addr !== 8'h05) begin
      miscompares++;
      $display("FAIL read_strobe: got r%b w%b a%h want 1 0 05", reg_r_en, reg_w_en, reg_addr);
    end
    tick();
    vectors++;
    if (reg_r_en !== 1'b0 || r_valid !== 2'b00) begin
      miscompares++;
      $display("FAIL read_n3: got r_en=%b valid=%b want 0/00", reg_r_en, r_valid);
    end
    tick();
    vectors++;
    if (r_valid !== 2'b00 || r_data !== 32'h0) begin
      miscompares++;
      $display("FAIL read_n4: got valid=%b data=%h want 00/00000000", r_valid, r_data);
    end
    tick();
    vectors++;
    if (r_valid !== 2'b10 || r_data !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL read_return: got valid=%b data=%h want 10/cafef00d", r_valid, r_data);
    end
    tick();
    vectors++;
    if (r_valid !== 2'b00 || r_data !== 32'hCAFE_F00D || pending !== 2'b00) begin
      miscompares++;
      $display("FAIL read_after: got valid=%b data=%h pending=%b want 00/cafef00d/00", r_valid, r_data, pending);
    end
  endtask

  task automatic test_pairs();
    logic [7:0] a0;
    for (int p = 0; p < 4; p++) begin
      a0 = 8'h30 + 8'(2 * p);
      w_en = 2'b11; w_addr = {a0 + 8'h01, a0};
      w_data = {32'h1111_0000 + 32'(p), 32'h2222_0000 + 32'(p)};
      tick();
      w_en = 2'b00;
      tick();
      vectors++;
      if (reg_w_en !== 1'b1 || reg_addr !== a0 || reg_w_data !== 32'h2222_0000 + 32'(p)) begin
        miscompares++;
        $display("FAIL pair%0d_first: got w%b a%h d%h want 1 %h %h", p, reg_w_en, reg_addr, reg_w_data, a0, 32'h2222_0000 + 32'(p));
      end
      tick(); tick();
      vectors++;
      if (reg_w_en !== 1'b1 || reg_addr !== a0 + 8'h01) begin
        miscompares++;
        $display("FAIL pair%0d_second: got w%b a%h want 1 %h", p, reg_w_en, reg_addr, a0 + 8'h01);
      end
      tick();
    end
  endtask

  task automatic test_retire_capture();
    logic [7:0] exp2, exp3;
    exp2 = FIXED ? 8'h42 : 8'h41;
    exp3 = FIXED ? 8'h41 : 8'h42;
    w_en = 2'b11; w_addr = {8'h41, 8'h40};
    tick();
    w_en = 2'b00;
    tick();
    vectors++;
    if (reg_w_en !== 1'b1 || reg_addr !== 8'h40) begin
      miscompares++;
      $display("FAIL rc_first: got w%b a%h want 1 40", reg_w_en, reg_addr);
    end
    w_en = 2'b01; w_addr[7:0] = 8'h42;
    tick();
    w_en = 2'b00;
    vectors++;
    if (pending !== 2'b11 || drop !== 2'b00) begin
      miscompares++;
      $display("FAIL rc_recapture: got pending=%b drop=%b want 11/00", pending, drop);
    end
    tick();
    vectors++;
    if (reg_w_en !== 1'b1 || reg_addr !== exp2) begin
      miscompares++;
      $display("FAIL rc_second: got w%b a%h want 1 %h", reg_w_en, reg_addr, exp2);
    end
    tick(); tick();
    vectors++;
    if (reg_w_en !== 1'b1 || reg_addr !== exp3) begin
      miscompares++;
      $display("FAIL rc_third: got w%b a%h want 1 %h", reg_w_en, reg_addr, exp3);
    end
    tick();
    vectors++;
    if (pending !== 2'b00) begin
      miscompares++;
      $display("FAIL rc_drained: got pending=%b want 00", pending);
    end
  endtask

  task automatic test_drop();
    int base;
    base = wr_count;
    w_en = 2'b01; w_addr[7:0] = 8'h50; w_data[31:0] = 32'h5050_5050;
    tick();
    w_addr[7:0] = 8'h51; w_data[31:0] = 32'h5151_5151;
    tick();
    w_en = 2'b00;
    vectors++;
    if (drop !== 2'b01 || reg_w_en !== 1'b1 || reg_addr !== 8'h50) begin
      miscompares++;
      $display("FAIL drop_set: got drop=%b w%b a%h want 01 1 50", drop, reg_w_en, reg_addr);
    end
    repeat (6) tick();
    vectors++;
    if (wr_count - base !== 1 || drop !== 2'b01 || pending !== 2'b00) begin
      miscompares++;
      $display("FAIL drop_sticky: got writes=%0d drop=%b pending=%b want 1/01/00", wr_count - base, drop, pending);
    end
  endtask

  task automatic test_wr_conflict();
    int wbase, rbase;
    wbase = wr_count; rbase = rd_count;
    w_en = 2'b10; r_en = 2'b10; w_addr[15:8] = 8'h60; r_addr[15:8] = 8'h61;
    tick();
    w_en = 2'b00; r_en = 2'b00;
    tick();
    vectors++;
    if (reg_w_en !== 1'b1 || reg_addr !== 8'h60) begin
      miscompares++;
      $display("FAIL conflict_write: got w%b a%h want 1 60", reg_w_en, reg_addr);
    end
    repeat (5) tick();
    vectors++;
    if (wr_count - wbase !== 1 || rd_count - rbase !== 0 || drop !== 2'b11 || pending !== 2'b00) begin
      miscompares++;
      $display("FAIL conflict_after: got writes=%0d reads=%0d drop=%b pending=%b want 1/0/11/00",
               wr_count - wbase, rd_count - rbase, drop, pending);
    end
  endtask

  task automatic test_reset_midop();
    int vbase;
    vbase = rv_count;
    r_en = 2'b01; r_addr[7:0] = 8'h70;
    tick();
    r_en = 2'b00;
    tick(); tick();
    rst = 1'b1;
    #1;
    vectors++;
    if ({reg_w_en, reg_r_en, reg_addr, reg_w_data, r_data, r_valid, pending, drop} !== '0) begin
      miscompares++;
      $display("FAIL reset_midop: got w%0b r%0b a%h d%h rd%h v%b p%b x%b want all 0",
               reg_w_en, reg_r_en, reg_addr, reg_w_data, r_data, r_valid, pending, drop);
    end
    tick();
    rst = 1'b0;
    repeat (6) tick();
    vectors++;
    if (rv_count !== vbase || pending !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_no_return: got returns=%0d pending=%b want %0d/00", rv_count, pending, vbase);
    end
    w_en = 2'b11; w_addr = {8'h81, 8'h80};
    tick();
    w_en = 2'b00;
    tick();
    vectors++;
    if (reg_w_en !== 1'b1 || reg_addr !== 8'h80) begin
      miscompares++;
      $display("FAIL reset_first_grant: got w%b a%h want 1 80", reg_w_en, reg_addr);
    end
    repeat (4) tick();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    wr_count = 0; rd_count = 0; rv_count = 0;
    rd_pipe = '0; bank_val = '0;
    w_en = '0; w_addr = '0; w_data = '0; r_en = '0; r_addr = '0;
    rst = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_pairs();
    test_retire_capture();
    test_drop();
    test_wr_conflict();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
